// File: rtl/data_arith_narrow.sv
// Lane-parallel narrowing stage: IN_W -> OUT_W per lane by saturation or truncation,
// with per-lane overflow flags, a two-entry skid buffer and a saturating overflow-beat counter.

module data_arith_narrow_lane #(
   parameter int IN_W     = 32,
   parameter int OUT_W    = 16,
   parameter int SIGNED   = 1,
   parameter int SATURATE = 1
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout,
   output logic             ovf
);
   logic hi_ovf, lo_ovf;
   logic [OUT_W-1:0] max_v, min_v;

   generate
      if (SIGNED != 0) begin : g_signed
         // Fits iff all bits above the output sign bit replicate the input sign.
         assign hi_ovf = !din[IN_W-1] &&  (|din[IN_W-2:OUT_W-1]);
         assign lo_ovf =  din[IN_W-1] && !(&din[IN_W-2:OUT_W-1]);
         assign max_v  = {1'b0, {(OUT_W-1){1'b1}}};
         assign min_v  = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin : g_unsigned
         assign hi_ovf = |din[IN_W-1:OUT_W];
         assign lo_ovf = 1'b0;
         assign max_v  = {OUT_W{1'b1}};
         assign min_v  = '0;
      end
   endgenerate

   assign ovf = hi_ovf || lo_ovf;

   always_comb begin
      dout = din[OUT_W-1:0];
      if (SATURATE != 0) begin
         if (hi_ovf)      dout = max_v;
         else if (lo_ovf) dout = min_v;
      end
   end
endmodule

module data_arith_narrow #(
   parameter int IN_W     = 32,
   parameter int OUT_W    = 16,
   parameter int DEPTH    = 2,
   parameter int SIGNED   = 1,
   parameter int SATURATE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DEPTH*IN_W-1:0]  in,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DEPTH*OUT_W-1:0] out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DEPTH-1:0]       ovf,
   output logic [15:0]            ovf_count,
   input  logic                   clear
);
   generate
      if (IN_W <= OUT_W || OUT_W < 2) begin : g_bad_params
         $error("data_arith_narrow: need IN_W > OUT_W and OUT_W >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t                 state_q, state_d;
   logic [DEPTH*OUT_W-1:0] nar, main_q, skid_q;
   logic [DEPTH-1:0]       nar_ovf, main_ovf_q, skid_ovf_q;
   logic                   load_main, load_skid, move_skid, deliver;
   logic [15:0]            cnt_q;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_lane
         data_arith_narrow_lane #(
            .IN_W(IN_W), .OUT_W(OUT_W), .SIGNED(SIGNED), .SATURATE(SATURATE)
         ) u_lane (
            .din (in[i*IN_W +: IN_W]),
            .dout(nar[i*OUT_W +: OUT_W]),
            .ovf (nar_ovf[i])
         );
      end
   endgenerate

   // Handshake flags depend on registered state only, so out_ready never reaches in_ready.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign deliver   = out_valid && out_ready;
   assign out       = main_q;
   assign ovf       = main_ovf_q;
   assign ovf_count = cnt_q;

   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      case (state_q)
         EMPTY: if (in_valid) begin
            load_main = 1'b1;
            state_d   = ONE;
         end
         ONE: begin
            if (in_valid && out_ready) begin
               load_main = 1'b1;
            end else if (in_valid) begin
               load_skid = 1'b1;
               state_d   = FULL;
            end else if (out_ready) begin
               state_d   = EMPTY;
            end
         end
         FULL: if (out_ready) begin
            move_skid = 1'b1;
            state_d   = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         main_ovf_q <= '0;
         skid_q     <= '0;
         skid_ovf_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_main) begin
            main_q     <= nar;
            main_ovf_q <= nar_ovf;
         end else if (move_skid) begin
            main_q     <= skid_q;
            main_ovf_q <= skid_ovf_q;
         end
         if (load_skid) begin
            skid_q     <= nar;
            skid_ovf_q <= nar_ovf;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (clear)
         cnt_q <= '0;
      else if (deliver && (|main_ovf_q) && (cnt_q != 16'hFFFF))
         cnt_q <= cnt_q + 16'd1;
   end
endmodule

// File: tb/tb_data_arith_narrow.sv
// Scoreboard bench: four configurations (signed/unsigned x saturate/truncate) share one
// handshake stream; a monitor checks each against an arithmetic reference model.

module tb_data_arith_narrow;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] in_bus = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        clear = 1'b0;

   logic [31:0] o   [4];
   logic [1:0]  v   [4];
   logic [15:0] c   [4];
   logic        rdy [4];
   logic        vld [4];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // g: 0 signed/sat, 1 signed/trunc, 2 unsigned/sat, 3 unsigned/trunc
   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         data_arith_narrow #(
            .IN_W(32), .OUT_W(16), .DEPTH(2),
            .SIGNED(g < 2 ? 1 : 0), .SATURATE(g % 2 == 0 ? 1 : 0)
         ) dut (
            .clk(clk), .rst_n(rst_n), .in(in_bus), .in_valid(in_valid),
            .in_ready(rdy[g]), .out(o[g]), .out_valid(vld[g]), .out_ready(out_ready),
            .ovf(v[g]), .ovf_count(c[g]), .clear(clear)
         );
      end
   endgenerate

   typedef struct packed {
      logic [3:0][31:0] o;
      logic [3:0][1:0]  v;
   } exp_t;

   exp_t        q[$];
   logic [15:0] cnt_m [4] = '{default: 16'h0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer range test against the output range of the configuration.
   function automatic void narrow(input logic [31:0] x, input int g,
                                  output logic [15:0] r, output logic ov);
      bit     sg = (g < 2);
      bit     st = (g % 2 == 0);
      longint val = sg ? longint'($signed(x)) : longint'({32'h0, x});
      longint hi  = sg ? 64'sd32767  : 64'sd65535;
      longint lo  = sg ? -64'sd32768 : 64'sd0;
      ov = (val > hi) || (val < lo);
      r  = x[15:0];
      if (ov && st) r = (val > hi) ? hi[15:0] : lo[15:0];
   endfunction

   function automatic exp_t model(input logic [63:0] d);
      exp_t        e;
      logic [15:0] r;
      logic        ov;
      e = '0;
      for (int g = 0; g < 4; g++)
         for (int l = 0; l < 2; l++) begin
            narrow(d[l*32 +: 32], g, r, ov);
            e.o[g][l*16 +: 16] = r;
            e.v[g][l]          = ov;
         end
      return e;
   endfunction

   // Monitor: occupancy is the scoreboard depth; outputs compared against its head.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         for (int g = 0; g < 4; g++) cnt_m[g] = 16'h0;
      end else begin
         logic del, acc;
         for (int g = 0; g < 4; g++) begin
            chk($sformatf("out_valid%0d", g), 64'(vld[g]), 64'(q.size() != 0));
            chk($sformatf("in_ready%0d", g),  64'(rdy[g]), 64'(q.size() < 2));
            if (q.size() != 0)
               chk($sformatf("data%0d", g), 64'({o[g], v[g]}), 64'({q[0].o[g], q[0].v[g]}));
            chk($sformatf("ovf_count%0d", g), 64'(c[g]), 64'(cnt_m[g]));
         end
         del = out_ready && (q.size() != 0);
         acc = in_valid && (q.size() < 2);
         for (int g = 0; g < 4; g++) begin
            if (clear) cnt_m[g] = 16'h0;
            else if (del && q[0].v[g] != 2'b00 && cnt_m[g] != 16'hFFFF) cnt_m[g] = cnt_m[g] + 16'd1;
         end
         if (del) void'(q.pop_front());
         if (acc) q.push_back(model(in_bus));
      end
   end

   task automatic beat(input logic [63:0] d);
      int n = 0;
      in_bus   = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (!rdy[0] && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("accept_timeout", 64'(n), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rl();
      logic [31:0] b;
      case ($urandom_range(0, 5))
         0:       b = $urandom;
         1:       b = 32'h00007FFE + $urandom_range(0, 2);
         2:       b = 32'hFFFF7FFF + $urandom_range(0, 2);
         3:       b = 32'h0000FFFE + $urandom_range(0, 2);
         4:       b = $urandom_range(0, 300);
         default: b = 32'hFFFFFF00 + $urandom_range(0, 255);
      endcase
      return b;
   endfunction

   localparam logic [63:0] OVF_BEAT   = 64'h00010000_00010000;
   localparam logic [63:0] CLEAN_BEAT = 64'h00000012_00000034;

   initial begin
      #2;
      for (int g = 0; g < 4; g++) begin
         chk("rst_in_ready",  64'(rdy[g]), 64'd1);
         chk("rst_out_valid", 64'(vld[g]), 64'd0);
         chk("rst_out",       64'({o[g], v[g]}), 64'd0);
         chk("rst_count",     64'(c[g]), 64'd0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed boundary vectors
      beat({32'h00008000, 32'h00007FFF});
      beat({32'hFFFF7FFF, 32'hFFFF8000});
      beat({32'h00012345, 32'h0000FFFF});
      idle(3);

      // Backpressure: A and B fill both entries, C waits
      out_ready = 1'b0;
      beat({rl(), rl()});
      beat({rl(), rl()});
      in_bus = {rl(), rl()};
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("c_held", 64'(rdy[0]), 64'd0);
      out_ready = 1'b1;
      beat(in_bus);
      idle(3);

      // Streaming
      for (int i = 0; i < 8; i++) beat({rl(), rl()});
      idle(3);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_bus    = {rl(), rl()};
         out_ready = ($urandom_range(0, 2) != 0);
         clear     = ($urandom_range(0, 49) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
      idle(4);

      // Counter: 3 overflowing + 2 clean beats
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      beat(OVF_BEAT); beat(CLEAN_BEAT); beat(OVF_BEAT); beat(CLEAN_BEAT); beat(OVF_BEAT);
      idle(3);
      for (int g = 0; g < 4; g++) chk("count3", 64'(c[g]), 64'd3);

      // Counter saturation
      for (int i = 0; i < 65535; i++) beat(OVF_BEAT);
      idle(3);
      for (int g = 0; g < 4; g++) chk("count_sat", 64'(c[g]), 64'hFFFF);

      // Clear coinciding with an overflowing deliver
      beat(OVF_BEAT);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 4; g++) chk("clear_prio", 64'(c[g]), 64'd0);
      idle(2);

      // Asynchronous reset while FULL
      beat(OVF_BEAT);
      idle(2);
      out_ready = 1'b0;
      beat({rl(), rl()});
      beat({rl(), rl()});
      #1 rst_n = 1'b0;
      #1;
      for (int g = 0; g < 4; g++) begin
         chk("mid_rst_out_valid", 64'(vld[g]), 64'd0);
         chk("mid_rst_out",       64'({o[g], v[g]}), 64'd0);
         chk("mid_rst_count",     64'(c[g]), 64'd0);
         chk("mid_rst_in_ready",  64'(rdy[g]), 64'd1);
      end
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      beat({32'h00000ABC, 32'hFFFF0000});
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
